// File: rtl/y86_pkg.sv
// Y86-64 instruction codes and length-decode helpers shared by the fetch front end.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef logic [3:0] instr_len_t;

  // Returns {need_regids, need_valC}; undefined icodes need neither.
  function automatic logic [1:0] icode_len(input logic [3:0] icode);
    logic [1:0] r;
    r = 2'b00;
    case (icode)
      IHALT, INOP, IRET:               r = 2'b00;
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:    r = 2'b10;
      IJXX, ICALL:                     r = 2'b01;
      IIRMOVQ, IRMMOVQ, IMRMOVQ:       r = 2'b11;
      default:                         r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_len_decode.sv
// Combinational icode decode: operand needs, total byte length and illegal-icode flag.
module instr_len_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic       need_regids,
  output logic       need_valC,
  output instr_len_t instr_len,
  output logic       instr_err
);

  // Length is 1 opcode byte, plus 1 register byte, plus 8 constant bytes as needed.
  always_comb begin
    {need_regids, need_valC} = icode_len(icode);
    instr_err = (icode > IPOPQ);
    instr_len = 4'd1 + (need_regids ? 4'd1 : 4'd0) + (need_valC ? 4'd8 : 4'd0);
  end

endmodule

// File: rtl/fetch_byte_buffer.sv
// Fetch byte queue: aligned 8-byte words in, one whole variable-length instruction out.
module fetch_byte_buffer
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [63:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [63:0] instr_pc,
  output logic [79:0] instr_bytes,
  output logic [3:0]  instr_len,
  output logic        need_regids,
  output logic        need_valC,
  output logic        instr_err
);

  localparam int unsigned DEPTH = 16;
  localparam int unsigned PTR_W = 4;
  localparam int unsigned CNT_W = 5;

  logic [7:0]       buf_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [63:0]      head_pc;
  logic [63:0]      fetch_addr;
  logic [2:0]       skip;
  logic             outstanding;
  logic             drop;
  logic             halted;

  logic [3:0]       icode;
  logic             req_fire;
  logic             rsp_write;
  logic             pop;
  logic             pop_halts;
  logic [CNT_W-1:0] wr_n;
  logic [CNT_W-1:0] pop_n;

  assign icode = buf_q[rd_ptr][7:4];

  instr_len_decode u_len_decode (
    .icode       (icode),
    .need_regids (need_regids),
    .need_valC   (need_valC),
    .instr_len   (instr_len),
    .instr_err   (instr_err)
  );

  // Request only when the whole next word is guaranteed to fit.
  assign imem_req_valid = !reset && !outstanding && !halted && (count <= CNT_W'(8)) && !redirect_valid;
  assign imem_req_addr  = fetch_addr;
  assign instr_pc       = head_pc;
  assign instr_valid    = !halted && (count != '0) && (count >= CNT_W'(instr_len));

  // Handshake qualifiers and byte-count deltas for this cycle.
  always_comb begin
    req_fire  = imem_req_valid && imem_req_ready;
    rsp_write = imem_rsp_valid && !drop && !redirect_valid;
    pop       = instr_valid && instr_ready && !redirect_valid;
    pop_halts = (icode == IHALT) || instr_err;
    wr_n      = rsp_write ? CNT_W'(4'd8 - {1'b0, skip}) : '0;
    pop_n     = pop ? CNT_W'(instr_len) : '0;
  end

  // Gather up to 10 bytes starting at the read pointer, wrapping around the ring.
  always_comb begin
    instr_bytes = '0;
    for (int k = 0; k < 10; k++) begin
      instr_bytes[8*k +: 8] = buf_q[rd_ptr + PTR_W'(k)];
    end
  end

  // Ring storage: pack the useful bytes of each response word at the write pointer.
  always_ff @(posedge clk) begin
    if (!reset && rsp_write) begin
      for (int j = 0; j < 8; j++) begin
        if (3'(j) >= skip) begin
          buf_q[wr_ptr + PTR_W'(j) - PTR_W'(skip)] <= imem_rsp_data[8*j +: 8];
        end
      end
    end
  end

  // Control state: redirect overrides everything, else response write and pop combine.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_pc     <= RESET_PC;
      fetch_addr  <= {RESET_PC[63:3], 3'b000};
      skip        <= RESET_PC[2:0];
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      halted      <= 1'b0;
    end else if (redirect_valid) begin
      head_pc     <= redirect_pc;
      fetch_addr  <= {redirect_pc[63:3], 3'b000};
      skip        <= redirect_pc[2:0];
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      halted      <= 1'b0;
      outstanding <= outstanding && !imem_rsp_valid;
      drop        <= outstanding && !imem_rsp_valid;
    end else begin
      if (req_fire) begin
        outstanding <= 1'b1;
        fetch_addr  <= fetch_addr + 64'd8;
      end
      if (imem_rsp_valid) begin
        outstanding <= 1'b0;
        drop        <= 1'b0;
      end
      if (rsp_write) begin
        wr_ptr <= wr_ptr + PTR_W'(wr_n);
        skip   <= 3'd0;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + instr_len;
        head_pc <= head_pc + 64'(instr_len);
        if (pop_halts) halted <= 1'b1;
      end
      count <= count + wr_n - pop_n;
    end
  end

endmodule

// File: tb/tb_fetch_byte_buffer.sv
// Scoreboard bench for fetch_byte_buffer with an in-order, variable-latency memory model.
module tb_fetch_byte_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [63:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [63:0] instr_pc;
  logic [79:0] instr_bytes;
  logic [3:0]  instr_len;
  logic        need_regids;
  logic        need_valC;
  logic        instr_err;

  always #5 clk = ~clk;

  fetch_byte_buffer #(.RESET_PC(64'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_pc       (instr_pc),
    .instr_bytes    (instr_bytes),
    .instr_len      (instr_len),
    .need_regids    (need_regids),
    .need_valC      (need_valC),
    .instr_err      (instr_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instruction memory image and expected-instruction scoreboard.
  logic [7:0] mem [256];

  typedef struct {
    logic [63:0] pc;
    logic [3:0]  len;
    logic        err;
  } exp_t;
  exp_t exp_q [$];

  typedef struct {
    logic [63:0] addr;
    int          due;
  } req_t;
  req_t mq [$];

  int cyc       = 0;
  int req_cnt   = 0;
  int mem_lat   = 1;
  bit rand_rdy  = 1'b0;

  task automatic push_exp(input logic [63:0] pc, input logic [3:0] len, input logic err);
    exp_t e;
    e.pc  = pc;
    e.len = len;
    e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic put(input int a, input logic [7:0] b);
    mem[a] = b;
  endtask

  task automatic put_imm(input int a);
    for (int i = 0; i < 8; i++) mem[a + i] = 8'(8'hA0 + a + i);
  endtask

  function automatic logic [79:0] exp_bytes(input logic [63:0] pc, input logic [3:0] len);
    logic [79:0] b;
    b = '0;
    for (int k = 0; k < 10; k++) begin
      if (k < int'(len)) b[8*k +: 8] = mem[8'(pc + 64'(k))];
    end
    return b;
  endfunction

  function automatic logic [79:0] len_mask(input logic [3:0] len);
    logic [79:0] m;
    m = '0;
    for (int k = 0; k < 10; k++) begin
      if (k < int'(len)) m[8*k +: 8] = 8'hFF;
    end
    return m;
  endfunction

  // Memory model: answer queued requests once due, then capture this cycle's accept.
  always @(negedge clk) begin
    req_t r;
    cyc++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (reset) begin
      mq.delete();
    end else begin
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        r = mq.pop_front();
        imem_rsp_valid = 1'b1;
        for (int k = 0; k < 8; k++) imem_rsp_data[8*k +: 8] = mem[8'(r.addr + 64'(k))];
      end
      if (imem_req_valid && imem_req_ready) begin
        check("req_align", 80'(imem_req_addr[2:0]), 80'h0);
        r.addr = imem_req_addr;
        r.due  = cyc + mem_lat;
        mq.push_back(r);
        req_cnt++;
      end
    end
  end

  // Optional random request backpressure, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    imem_req_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Pop side: every consumed instruction must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && instr_valid && instr_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        check("extra_instr_pc", 80'(instr_pc), 80'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("pc",      80'(instr_pc), 80'(e.pc));
        check("len",     80'(instr_len), 80'(e.len));
        check("bytes",   instr_bytes & len_mask(e.len), exp_bytes(e.pc, e.len));
        check("err",     80'(instr_err), 80'(e.err));
        check("regids",  80'(need_regids), 80'((e.len == 4'd2) || (e.len == 4'd10)));
        check("valC",    80'(need_valC), 80'(e.len >= 4'd9));
      end
    end
  end

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    check(tag, 80'(exp_q.size()), 80'h0);
  endtask

  task automatic do_redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  task automatic check_halted(input string tag);
    int n;
    repeat (5) @(posedge clk);
    #1;
    n = req_cnt;
    repeat (10) @(posedge clk);
    #1;
    check({tag, "_no_req"}, 80'(req_cnt - n), 80'h0);
    check({tag, "_no_valid"}, 80'(instr_valid), 80'h0);
  endtask

  initial begin
    int n;
    reset          = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;

    // Stream at 0: irmovq, nop, ret, call straddling the ring wrap, opq, rrmovq, jmp, halt.
    put(0, 8'h30); put(1, 8'hF3); put_imm(2);
    put(10, 8'h10);
    put(11, 8'h90);
    put(12, 8'h80); put_imm(13);
    put(21, 8'h60); put(22, 8'h01);
    put(23, 8'h20); put(24, 8'h12);
    put(25, 8'h70); put_imm(26);
    put(34, 8'h00);
    // Stream at 0x40: opq, rmmovq, illegal icode F.
    put(8'h40, 8'h63); put(8'h41, 8'h00);
    put(8'h42, 8'h40); put(8'h43, 8'h12); put_imm(8'h44);
    put(8'h4C, 8'hF0);
    // Unaligned target 0x93: rrmovq then halt; 0xA0.. stays 0xFF garbage.
    put(8'h93, 8'h20); put(8'h94, 8'h45);
    put(8'h95, 8'h00);
    // Stream at 0xC0 for the backpressure test.
    put(8'hC0, 8'h10);
    put(8'hC1, 8'h60); put(8'hC2, 8'h12);
    put(8'hC3, 8'h30); put(8'hC4, 8'hF4); put_imm(8'hC5);
    put(8'hCD, 8'h90);
    put(8'hCE, 8'h61); put(8'hCF, 8'h23);
    put(8'hD0, 8'h70); put_imm(8'hD1);
    put(8'hD9, 8'h00);

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", 80'(imem_req_valid), 80'h0);
    check("rst_instr_valid", 80'(instr_valid), 80'h0);

    push_exp(64'd0, 4'd10, 1'b0);
    push_exp(64'd10, 4'd1, 1'b0);
    push_exp(64'd11, 4'd1, 1'b0);
    push_exp(64'd12, 4'd9, 1'b0);
    push_exp(64'd21, 4'd2, 1'b0);
    push_exp(64'd23, 4'd2, 1'b0);
    push_exp(64'd25, 4'd9, 1'b0);
    push_exp(64'd34, 4'd1, 1'b0);
    reset       = 1'b0;
    instr_ready = 1'b1;
    wait_drain("drain_reset_stream");
    check_halted("halt");

    // Restart after halt, with random request backpressure; illegal icode halts again.
    rand_rdy = 1'b1;
    push_exp(64'h40, 4'd2, 1'b0);
    push_exp(64'h42, 4'd10, 1'b0);
    push_exp(64'h4C, 4'd1, 1'b1);
    do_redirect(64'h40);
    wait_drain("drain_0x40");
    rand_rdy = 1'b0;
    check_halted("err_halt");

    // Redirect while a slow response is outstanding: the stale word must be dropped.
    instr_ready = 1'b0;
    mem_lat     = 3;
    n = req_cnt;
    do_redirect(64'hA0);
    for (int i = 0; i < 50 && req_cnt == n; i++) begin
      @(posedge clk);
      #1;
    end
    check("stale_req_issued", 80'(req_cnt - n), 80'h1);
    push_exp(64'h93, 4'd2, 1'b0);
    push_exp(64'h95, 4'd1, 1'b0);
    instr_ready = 1'b1;
    do_redirect(64'h93);
    wait_drain("drain_0x93");
    mem_lat = 1;

    // Downstream stalled for 20 cycles: buffer fills to 16 bytes with exactly two words.
    instr_ready = 1'b0;
    push_exp(64'hC0, 4'd1, 1'b0);
    push_exp(64'hC1, 4'd2, 1'b0);
    push_exp(64'hC3, 4'd10, 1'b0);
    push_exp(64'hCD, 4'd1, 1'b0);
    push_exp(64'hCE, 4'd2, 1'b0);
    push_exp(64'hD0, 4'd9, 1'b0);
    push_exp(64'hD9, 4'd1, 1'b0);
    do_redirect(64'hC0);
    n = req_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("stall_req_count", 80'(req_cnt - n), 80'h2);
    check("stall_valid", 80'(instr_valid), 80'h1);
    check("stall_pc", 80'(instr_pc), 80'hC0);
    instr_ready = 1'b1;
    wait_drain("drain_stall");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
